sha256_w_sched_ctrl: RTL and testbench
======================================

SHA256_W_SCHED_CTRL -- requirements
Module: sha256_w_sched_ctrl

Interface
REQ-001 SHALL have no parameters: word width fixed at 32, window depth 16, round count 64.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port blk_valid  input  1  new 512-bit message block offered.
REQ-005 SHALL have port blk_ready  output  1  controller can accept a block.
REQ-006 SHALL have port block_in  input  512  message block, W0 = [511:480] ... W15 = [31:0].
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current block.
REQ-008 SHALL have port w_valid  output  1  w_out holds schedule word W[t].
REQ-009 SHALL have port w_ready  input  1  consumer accepts w_out this cycle.
REQ-010 SHALL have port w_out  output  32  schedule word W[t].
REQ-011 SHALL have port w_idx  output  6  round index t of w_out.
REQ-012 SHALL have port busy  output  1  high in RUN state.
REQ-013 SHALL have port done  output  1  one-cycle pulse after W63 is accepted.

Function
REQ-014 SHALL implement states IDLE and RUN, with registered state, t counter (6 bit) and a 16x32 window win[0..15].
REQ-015 In IDLE: blk_ready=1, w_valid=0, busy=0.
REQ-016 In IDLE, on blk_valid=1: load win[i] = block_in word i; set t=0; enter RUN on the next cycle.
REQ-017 In RUN: blk_ready=0, busy=1, w_valid=1, w_out=win[0], w_idx=t; blk_valid is ignored.
REQ-018 In RUN, on w_ready=1 (transfer), the window SHALL shift as follows:
  - win[i] <= win[i+1] for i = 0..14;
  - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32;
  - t <= t+1.
REQ-019 s0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x); s1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-020 With w_ready=0 in RUN, window, t and outputs SHALL hold unchanged (stall); w_out stable while w_valid=1 and w_ready=0.
REQ-021 Transfer at t=63 SHALL:
  - return to IDLE;
  - assert done for exactly the next cycle;
  - not wrap t into a new round 0 of the same block.
REQ-022 A block SHALL be accepted in the cycle done is high; back-to-back blocks therefore have a 1-cycle bubble minimum.
REQ-023 abort=1 SHALL force IDLE next cycle from any state, with t=0 and no done pulse; abort has priority over transfer, load and done.
REQ-024 abort=1 together with blk_valid=1 in IDLE SHALL NOT load the block.
REQ-025 Words W16..W63 SHALL be produced strictly in order with no skipped or repeated index; exactly 64 transfers per accepted block.
REQ-026 All outputs SHALL be driven from registers or state decode only; no combinational path from w_ready to w_out or w_idx.

Reset
REQ-027 RST=0 SHALL asynchronously force IDLE, t=0, win all zero, done=0, w_valid=0, busy=0, blk_ready=1 (while RST=0: blk_ready=0), w_out=0, w_idx=0.
REQ-028 Reset asserted mid-RUN SHALL discard the block; after release the controller waits in IDLE for a new blk_valid.

Verification
REQ-029 Load "abc" padded block (W0=0x61626380, W15=0x00000018, others 0), w_ready=1 always -> expect:
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000;
  - done pulse one cycle after the W63 transfer;
  - 64 total transfers.
REQ-030 All-zero block -> all 64 words 0x00000000 and w_idx 0..63 in order.
REQ-031 "abc" block with w_ready toggled pseudo-randomly -> identical word sequence to REQ-029; w_out and w_idx stable throughout each stall.
REQ-032 abort at t=20 -> next cycle IDLE, blk_ready=1, no done; a new block then restarts at w_idx=0 with correct words.
REQ-033 RST pulsed low at t=40 -> all outputs at reset values immediately; after release, no w_valid until the next blk_valid.
REQ-034 blk_valid held high continuously -> second block loads in the done cycle; second block's W0 appears 2 cycles after the first block's W63 transfer.

Source files
------------

// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message schedule controller.
// Streams W0..W63 for each 512-bit block over a valid/ready port.
module sha256_w_sched_ctrl (
    input  logic         CLK,
    input  logic         RST,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] block_in,
    input  logic         abort,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         busy,
    output logic         done
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [5:0] LAST_T = 6'd63;

    logic        r_state;
    logic [5:0]  r_t;
    logic        r_done;
    logic [31:0] r_win [16];

    logic        w_load;
    logic        w_xfer;
    logic        w_last;
    logic [31:0] w_new;

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Handshake decode; abort blocks both a new load and a transfer.
    always_comb begin
        w_load = (r_state == ST_IDLE) && blk_valid && !abort;
        w_xfer = (r_state == ST_RUN) && w_ready && !abort;
        w_last = w_xfer && (r_t == LAST_T);
        w_new  = f_s1(r_win[14]) + r_win[9]
               + f_s0(r_win[1]) + r_win[0];
    end

    // Control state, round counter and the one-cycle done pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_t     <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_t     <= 6'd0;
            end else if (w_load) begin
                r_state <= ST_RUN;
                r_t     <= 6'd0;
            end else if (w_last) begin
                r_state <= ST_IDLE;
                r_t     <= 6'd0;
                r_done  <= 1'b1;
            end else if (w_xfer) begin
                r_t <= r_t + 6'd1;
            end
        end
    end

    // Sliding 16-word window: load a block or shift in the next word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else if (w_load) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= block_in[511 - 32*i -: 32];
            end
        end else if (w_xfer) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_new;
        end
    end

    // Outputs come straight from registers or state decode.
    always_comb begin
        blk_ready = (r_state == ST_IDLE) && RST;
        w_valid   = (r_state == ST_RUN);
        busy      = (r_state == ST_RUN);
        done      = r_done;
        w_out     = r_win[0];
        w_idx     = r_t;
    end

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Bench for sha256_w_sched_ctrl.
// Reference schedule is the textbook 64-entry W array.
module tb_sha256_w_sched_ctrl;

    logic         CLK;
    logic         RST;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] block_in;
    logic         abort;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  exp_w [64];
    logic [31:0]  got_w [64];
    logic [511:0] abc_blk;

    sha256_w_sched_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .block_in  (block_in),
        .abort     (abort),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .w_idx     (w_idx),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x,
                                         input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) begin
            exp_w[t] = blk[511 - 32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7]
                     + sig0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[32*i +: 32] = $urandom;
        end
        return b;
    endfunction

    // Offer a block in IDLE; returns at the first RUN cycle.
    task automatic load_block(input logic [511:0] blk);
        block_in  = blk;
        blk_valid = 1'b1;
        n_checks++;
        if (blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready got=%b exp=1", blk_ready);
        end
        @(negedge CLK);
        blk_valid = 1'b0;
    endtask

    // Drain 64 words, checking order, value and stall stability.
    task automatic run_block(input logic [511:0] blk,
                             input bit rand_rdy,
                             input bit tail);
        int idx;
        int cyc;
        bit stalled;
        bit rdy;
        logic [31:0] p_out;
        logic [5:0]  p_idx;
        compute_model(blk);
        idx = 0;
        cyc = 0;
        stalled = 0;
        p_out = '0;
        p_idx = '0;
        while (idx < 64 && cyc < 1000) begin
            n_checks++;
            if ({w_valid, w_idx, w_out} !==
                {1'b1, 6'(idx), exp_w[idx]}) begin
                n_fail++;
                $display("FAIL word t=%0d got v=%b i=%0d w=%h exp v=1 i=%0d w=%h",
                         idx, w_valid, w_idx, w_out, idx, exp_w[idx]);
            end
            if (stalled) begin
                n_checks++;
                if (w_out !== p_out || w_idx !== p_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold got i=%0d w=%h exp i=%0d w=%h",
                             w_idx, w_out, p_idx, p_out);
                end
            end
            got_w[idx] = w_out;
            rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            w_ready = rdy;
            stalled = !rdy;
            p_out = w_out;
            p_idx = w_idx;
            if (rdy) idx++;
            cyc++;
            @(negedge CLK);
        end
        w_ready = 1'b0;
        n_checks++;
        if (idx != 64) begin
            n_fail++;
            $display("FAIL xfer_count got=%0d exp=64", idx);
        end
        if (tail) begin
            n_checks++;
            if ({done, w_valid, busy, blk_ready} !== 4'b1001) begin
                n_fail++;
                $display("FAIL done_cycle got d=%b v=%b b=%b r=%b exp 1 0 0 1",
                         done, w_valid, busy, blk_ready);
            end
            @(negedge CLK);
            n_checks++;
            if ({done, w_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL done_width got d=%b v=%b exp 0 0",
                         done, w_valid);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({blk_ready, w_valid, busy, done, w_idx, w_out} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_out got r=%b v=%b b=%b d=%b i=%0d w=%h exp all 0",
                     blk_ready, w_valid, busy, done, w_idx, w_out);
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_checks++;
        if (blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release got r=%b exp 1", blk_ready);
        end
        @(negedge CLK);
    endtask

    task automatic test_abc();
        load_block(abc_blk);
        run_block(abc_blk, 0, 1);
        n_checks++;
        if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h18) begin
            n_fail++;
            $display("FAIL abc_w0_w15 got %h %h exp 61626380 00000018",
                     got_w[0], got_w[15]);
        end
        n_checks++;
        if (got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000) begin
            n_fail++;
            $display("FAIL abc_w16_w17 got %h %h exp 61626380 000f0000",
                     got_w[16], got_w[17]);
        end
    endtask

    task automatic test_zero();
        load_block('0);
        run_block('0, 0, 1);
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got_w[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL zero_word t=%0d got %h exp 0", i, got_w[i]);
            end
        end
    endtask

    task automatic test_stall();
        load_block(abc_blk);
        run_block(abc_blk, 1, 1);
        n_checks++;
        if (got_w[17] !== 32'h000F0000) begin
            n_fail++;
            $display("FAIL stall_w17 got %h exp 000f0000", got_w[17]);
        end
    endtask

    task automatic test_abort();
        logic [511:0] b;
        b = rand_block();
        compute_model(b);
        load_block(b);
        for (int i = 0; i < 20; i++) begin
            w_ready = 1'b1;
            @(negedge CLK);
        end
        n_checks++;
        if (w_idx !== 6'd20 || w_out !== exp_w[20]) begin
            n_fail++;
            $display("FAIL abort_pre got i=%0d w=%h exp i=20 w=%h",
                     w_idx, w_out, exp_w[20]);
        end
        abort   = 1'b1;
        w_ready = 1'b1;
        @(negedge CLK);
        abort   = 1'b0;
        w_ready = 1'b0;
        n_checks++;
        if ({w_valid, busy, done, blk_ready, w_idx} !== {4'b0001, 6'd0}) begin
            n_fail++;
            $display("FAIL abort_idle got v=%b b=%b d=%b r=%b i=%0d exp 0 0 0 1 0",
                     w_valid, busy, done, blk_ready, w_idx);
        end
        @(negedge CLK);
        n_checks++;
        if ({done, w_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_nodone got d=%b v=%b exp 0 0", done, w_valid);
        end
        abort     = 1'b1;
        blk_valid = 1'b1;
        block_in  = b;
        @(negedge CLK);
        abort     = 1'b0;
        blk_valid = 1'b0;
        n_checks++;
        if (w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_noload got v=%b exp 0", w_valid);
        end
        load_block(abc_blk);
        run_block(abc_blk, 0, 1);
    endtask

    task automatic test_reset_mid();
        logic [511:0] b;
        b = rand_block();
        load_block(b);
        for (int i = 0; i < 40; i++) begin
            w_ready = 1'b1;
            @(negedge CLK);
        end
        w_ready = 1'b0;
        n_checks++;
        if (w_idx !== 6'd40) begin
            n_fail++;
            $display("FAIL rst_pre got i=%0d exp 40", w_idx);
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if ({blk_ready, w_valid, busy, done, w_idx, w_out} !== 40'd0) begin
            n_fail++;
            $display("FAIL rst_mid got r=%b v=%b b=%b d=%b i=%0d w=%h exp all 0",
                     blk_ready, w_valid, busy, done, w_idx, w_out);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({w_valid, blk_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL rst_wait got v=%b r=%b exp 0 1",
                         w_valid, blk_ready);
            end
        end
        b = rand_block();
        load_block(b);
        run_block(b, 1, 1);
    endtask

    task automatic test_back_to_back();
        logic [511:0] a;
        logic [511:0] b;
        logic [31:0]  b0;
        a = rand_block();
        b = rand_block();
        b0 = b[511 -: 32];
        block_in  = a;
        blk_valid = 1'b1;
        @(negedge CLK);
        block_in = b;
        run_block(a, 0, 0);
        n_checks++;
        if ({done, blk_ready, w_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_done got d=%b r=%b v=%b exp 1 1 0",
                     done, blk_ready, w_valid);
        end
        @(negedge CLK);
        blk_valid = 1'b0;
        n_checks++;
        if ({w_valid, w_idx, w_out} !== {1'b1, 6'd0, b0}) begin
            n_fail++;
            $display("FAIL b2b_w0 got v=%b i=%0d w=%h exp v=1 i=0 w=%h",
                     w_valid, w_idx, w_out, b0);
        end
        run_block(b, 0, 1);
    endtask

    task automatic test_random_blocks();
        logic [511:0] b;
        for (int k = 0; k < 3; k++) begin
            b = rand_block();
            load_block(b);
            run_block(b, 1, 1);
        end
    endtask

    initial begin
        RST       = 1'b0;
        blk_valid = 1'b0;
        block_in  = '0;
        abort     = 1'b0;
        w_ready   = 1'b0;
        abc_blk   = {32'h61626380, 448'd0, 32'h00000018};
        test_reset();
        test_abc();
        test_zero();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random_blocks();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
